// File: rtl/sample_ram_arbiter.sv
// rtl/sample_ram_arbiter.sv - single-port sample RAM arbiter: write FIFO, read priority, bounded writer starvation
// Optional read-after-write bypass from pending FIFO entries: define SAMPLE_RAM_ARB_BYPASS_EN.
module sample_ram_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_STARVE = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic                          rd_ready,
    output logic                          rd_valid,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [DATA_W-1:0]             ram_wdata,
    input  logic [DATA_W-1:0]             ram_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(MAX_STARVE + 1);

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [ST_W-1:0]   starve_cnt;
    logic              rd_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic fifo_empty;
    logic fifo_full;
    logic starved;
    logic wr_grant;
    logic rd_grant;
    logic push;

    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == CNT_W'(FIFO_DEPTH));
        starved    = (starve_cnt == ST_W'(MAX_STARVE));
        wr_grant   = !reset && !fifo_empty && (!rd_req || starved);
        rd_grant   = !reset && rd_req && !wr_grant;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push       = !reset && wr_en && (!fifo_full || wr_grant);
    end

    always_comb begin
        rd_ready  = rd_grant;
        ram_en    = wr_grant || rd_grant;
        ram_we    = wr_grant;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        if (wr_grant) begin
            ram_addr  = fifo_addr[head];
            ram_wdata = fifo_data[head];
        end else if (rd_grant) begin
            ram_addr  = rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[tail] <= wr_addr;
            fifo_data[tail] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            starve_cnt <= '0;
            overflow   <= 1'b0;
            rd_valid_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (wr_grant) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(wr_grant);
            if (wr_en && !push) begin
                overflow <= 1'b1;
            end
            if (wr_grant || fifo_empty) begin
                starve_cnt <= '0;
            end else if (rd_grant && !starved) begin
                starve_cnt <= starve_cnt + ST_W'(1);
            end
            rd_valid_q <= rd_grant;
            addr_q     <= ram_addr;
            wdata_q    <= ram_wdata;
        end
    end

    assign fifo_count = count;
    // Reset squashes a read that was granted in the previous cycle.
    assign rd_valid   = rd_valid_q && !reset;

`ifdef SAMPLE_RAM_ARB_BYPASS_EN
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;
    logic              byp_hit_q;
    logic [DATA_W-1:0] byp_data_q;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (CNT_W'(i) < count && fifo_addr[head + PTR_W'(i)] == rd_addr) begin
                byp_hit  = 1'b1;
                byp_data = fifo_data[head + PTR_W'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_hit_q  <= rd_grant && byp_hit;
            byp_data_q <= byp_data;
        end
    end

    assign rd_data = rd_valid ? (byp_hit_q ? byp_data_q : ram_rdata) : '0;
`else
    assign rd_data = rd_valid ? ram_rdata : '0;
`endif

endmodule

// File: tb/tb_sample_ram_arbiter.sv
// tb/tb_sample_ram_arbiter.sv - self-checking bench for sample_ram_arbiter with a queue-based reference model
module tb_sample_ram_arbiter;
    localparam int DEPTH = 4;
    localparam int MAXS  = 8;

    logic       clk = 1'b0;
    logic       reset, wr_en, rd_req;
    logic [8:0] wr_addr, rd_addr, ram_addr;
    logic [7:0] wr_data, ram_wdata, rd_data;
    logic [7:0] ram_rdata = 8'h00;
    logic       rd_ready, rd_valid, ram_en, ram_we, overflow;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    sample_ram_arbiter dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .fifo_count(fifo_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    logic [7:0] ram_mem [512];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    typedef struct packed {logic [8:0] a; logic [7:0] d;} ent_t;
    ent_t       mq[$];
    logic [7:0] mmem [512];
    int         starve;
    bit         movf, mvalid;
    logic [7:0] mdata;
    bit         eg_w, eg_r;
    bit         s_rst, s_rq, s_we;
    logic [8:0] s_ra, s_wa;
    logic [7:0] s_wd;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_check();
        eg_w = !s_rst && mq.size() > 0 && (!s_rq || starve == MAXS);
        eg_r = !s_rst && s_rq && !eg_w;
        chk("rd_ready", rd_ready, eg_r);
        chk("ram_en", ram_en, eg_w || eg_r);
        if (eg_w || eg_r) begin
            chk("ram_we", ram_we, eg_w);
            chk("ram_addr", ram_addr, eg_w ? mq[0].a : s_ra);
        end
        if (eg_w) chk("ram_wdata", ram_wdata, mq[0].d);
        chk("rd_valid", rd_valid, mvalid && !s_rst);
        if (mvalid && !s_rst) chk("rd_data", rd_data, mdata);
        chk("fifo_count", fifo_count, mq.size());
        chk("overflow", overflow, movf);
    endtask

    task automatic model_update();
        int n0;
        if (s_rst) begin
            mq.delete();
            starve = 0;
            movf   = 0;
            mvalid = 0;
            return;
        end
        n0     = mq.size();
        mvalid = eg_r;
        if (eg_r) begin
            mdata = mmem[s_ra];
`ifdef SAMPLE_RAM_ARB_BYPASS_EN
            for (int i = 0; i < n0; i++) if (mq[i].a == s_ra) mdata = mq[i].d;
`endif
        end
        if (eg_w) begin
            mmem[mq[0].a] = mq[0].d;
            void'(mq.pop_front());
        end
        if (s_we) begin
            if (mq.size() < DEPTH) mq.push_back('{a: s_wa, d: s_wd});
            else movf = 1;
        end
        if (eg_w || n0 == 0) starve = 0;
        else if (eg_r && starve < MAXS) starve++;
    endtask

    task automatic drive(input bit rst, input bit rq, input logic [8:0] ra,
                         input bit we, input logic [8:0] wa, input logic [7:0] wd);
        reset = rst; rd_req = rq; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd;
        s_rst = rst; s_rq = rq; s_ra = ra; s_we = we; s_wa = wa; s_wd = wd;
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0);
        tick();
    endtask

    function automatic logic [8:0] pick_addr();
        return ($urandom_range(0, 1) ? 9'h1A0 : 9'h0C0) + 9'($urandom_range(0, 3));
    endfunction

    typedef struct {
        bit rq; bit we; bit exp_ready; bit exp_we; int exp_cnt; bit exp_ovf;
    } vec_t;
    vec_t vt[11];

    initial begin
        int  wcnt;
        int  wpos[3];
        bit  cur_rq, w, rst;
        logic [8:0] cur_ra;

        for (int i = 0; i < 512; i++) begin
            ram_mem[i] = 8'(i) ^ 8'h5A;
            mmem[i]    = 8'(i) ^ 8'h5A;
        end
        starve = 0; movf = 0; mvalid = 0; mdata = 0;

        // Overflow then full-with-pop: rd_req held, 6 pushes, push again on the forced write cycle.
        vt[0]  = '{1, 1, 1, 0, 0, 0};
        vt[1]  = '{1, 1, 1, 0, 1, 0};
        vt[2]  = '{1, 1, 1, 0, 2, 0};
        vt[3]  = '{1, 1, 1, 0, 3, 0};
        vt[4]  = '{1, 1, 1, 0, 4, 0};
        vt[5]  = '{1, 1, 1, 0, 4, 1};
        vt[6]  = '{1, 0, 1, 0, 4, 1};
        vt[7]  = '{1, 0, 1, 0, 4, 1};
        vt[8]  = '{1, 0, 1, 0, 4, 1};
        vt[9]  = '{1, 1, 0, 1, 4, 1};
        vt[10] = '{1, 0, 1, 0, 4, 1};

        reset = 1; rd_req = 0; rd_addr = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        @(posedge clk);
        @(negedge clk);
        do_reset();

        drive(0, 0, 0, 0, 0, 0);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        tick();

        for (int i = 0; i < 256; i++) begin
            drive(0, 0, 0, 1, 9'(i), 8'(8'h80 + i));
            chk("wo_fifo_le1", int'(fifo_count <= 1), 1);
            tick();
            drive(0, 0, 0, 0, 0, 0);
            chk("wo_ram_we", int'(ram_en && ram_we), 1);
            chk("wo_ram_addr", ram_addr, i);
            chk("wo_ram_wdata", ram_wdata, 8'(8'h80 + i));
            tick();
        end
        chk("wo_overflow", overflow, 0);
        do_reset();

        for (int k = 0; k < 11; k++) begin
            drive(0, vt[k].rq, 9'h030, vt[k].we, 9'h040 + 9'(k), 8'(k + 1));
            chk("tv_rd_ready", rd_ready, vt[k].exp_ready);
            chk("tv_ram_we", int'(ram_en && ram_we), vt[k].exp_we);
            chk("tv_fifo_count", fifo_count, vt[k].exp_cnt);
            chk("tv_overflow", overflow, vt[k].exp_ovf);
            tick();
        end
        do_reset();
        drive(0, 0, 0, 0, 0, 0);
        chk("ovf_cleared_by_reset", overflow, 0);
        tick();
        do_reset();

        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 9'h031, (k < 4) || (k == 9), 9'h060 + 9'(k), 8'(8'hA0 + k));
            if (k == 9) begin
                chk("fp_rd_ready", rd_ready, 0);
                chk("fp_ram_we", int'(ram_en && ram_we), 1);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("fp_fifo_count", fifo_count, 4);
        chk("fp_overflow", overflow, 0);
        tick();
        do_reset();

        wcnt = 0;
        for (int k = 0; k < 40; k++) begin
            drive(0, 1, 9'h032, k < 3, 9'h070 + 9'(k), 8'(8'hC0 + k));
            if (ram_en && ram_we) begin
                if (wcnt < 3) wpos[wcnt] = k;
                wcnt++;
            end
            tick();
        end
        chk("st_wcnt", wcnt, 3);
        chk("st_w0", wpos[0], 9);
        chk("st_w1", wpos[1], 18);
        chk("st_w2", wpos[2], 27);
        drive(0, 0, 0, 0, 0, 0);
        chk("st_fifo_empty", fifo_count, 0);
        tick();
        do_reset();

        drive(0, 1, 9'h010, 1, 9'h1A5, 8'h3C);
        tick();
        drive(0, 1, 9'h1A5, 0, 0, 0);
        chk("byp_rd_ready", rd_ready, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("byp_rd_valid", rd_valid, 1);
`ifdef SAMPLE_RAM_ARB_BYPASS_EN
        chk("byp_rd_data", rd_data, 8'h3C);
`else
        chk("byp_rd_data", rd_data, 8'hFF);
`endif
        tick();
        do_reset();

        drive(0, 1, 9'h020, 1, 9'h100, 8'h11);
        tick();
        drive(0, 1, 9'h021, 1, 9'h101, 8'h22);
        tick();
        drive(0, 1, 9'h022, 0, 0, 0);
        chk("rm_grant", rd_ready, 1);
        chk("rm_pending", fifo_count, 2);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk("rm_rd_valid", rd_valid, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk("rm_fifo_count", fifo_count, 0);
            chk("rm_no_ram", ram_en, 0);
            tick();
        end

        cur_rq = 0;
        cur_ra = 0;
        for (int k = 0; k < 1500; k++) begin
            if (!cur_rq) begin
                cur_rq = ($urandom_range(0, 99) < 60);
                cur_ra = pick_addr();
            end
            w   = ($urandom_range(0, 99) < 35);
            rst = ($urandom_range(0, 299) == 0);
            drive(rst, cur_rq, cur_ra, w, pick_addr(), 8'($urandom));
            if (eg_r || rst) cur_rq = 0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sample_ram_arbiter.md
# sample_ram_arbiter

Shares the single-port 512x8 sample RAM between the capture-side writer (`wave_capture` write port) and the display-side reader (`wave_display` read port). Capture writes are buffered in a small write FIFO so they are never stalled. Display reads get priority, with bounded starvation of the writer. Sits between both blocks and the RAM macro, which has a 1-cycle synchronous read.

## Interface
Parameters:
- `ADDR_W`, 9, RAM address width (2 x 256-sample halves; MSB = buffer index)
- `DATA_W`, 8, sample width
- `FIFO_DEPTH`, 4, write FIFO entries; power of 2, ≥2
- `MAX_STARVE`, 8, max consecutive read grants while the FIFO is non-empty

Ports:
- `clk` in 1: single clock
- `reset` in 1: synchronous, active-high
- `wr_en` in 1: write strobe from capture, one pulse per sample
- `wr_addr` in ADDR_W: write address
- `wr_data` in DATA_W: write sample
- `rd_req` in 1: read request; held with `rd_addr` until `rd_ready`
- `rd_addr` in ADDR_W: read address
- `rd_ready` out 1: read granted this cycle (combinational)
- `rd_valid` out 1: `rd_data` valid, exactly 1 cycle after grant
- `rd_data` out DATA_W: read result, registered
- `ram_en` out 1, `ram_we` out 1, `ram_addr` out ADDR_W, `ram_wdata` out DATA_W: RAM port
- `ram_rdata` in DATA_W: RAM read data, 1 cycle after `ram_en & !ram_we`
- `fifo_count` out $clog2(FIFO_DEPTH)+1: entries pending
- `overflow` out 1: sticky; a write was dropped

## Operation
- Push: `wr_en` enqueues {addr, data} if `fifo_count < FIFO_DEPTH`, or if a write grant pops the FIFO in the same cycle. Otherwise the write is dropped and `overflow` is set (cleared only by reset).
- Arbitration, evaluated each cycle, one grant at most:
  - Write grant: FIFO non-empty and (`!rd_req` or `starve_cnt == MAX_STARVE`). Pops the head. Drives `ram_en=1`, `ram_we=1`, head addr/data.
  - Read grant: otherwise, if `rd_req`. Drives `rd_ready=1`, `ram_en=1`, `ram_we=0`, `ram_addr=rd_addr`.
  - Idle: `ram_en=0`; `ram_addr` and `ram_wdata` are don't-care but held at last value.
- `starve_cnt`:
  - increments on each read grant while the FIFO is non-empty
  - clears on a write grant, or when the FIFO is empty
  - saturates at MAX_STARVE
- FIFO order is strict; no write coalescing.
- Writes are never reordered relative to each other. A read granted before a write's RAM cycle returns old RAM data (except under the Configuration feature).
- Reset mid-operation: FIFO contents discarded, pointers/count/`starve_cnt` zeroed, an in-flight read's `rd_valid` suppressed.

## Timing
- Reset values:
  - `rd_ready=0`, `rd_valid=0`, `rd_data=0`
  - `ram_en=0`, `ram_we=0`, `ram_addr=0`, `ram_wdata=0`
  - `fifo_count=0`, `overflow=0`
- Write latency: `wr_en` at cycle N makes its RAM write cycle N+1 at earliest (FIFO registered, no cut-through).
- Read latency: grant at N gives `rd_valid=1` with `rd_data` at N+1, for one cycle.
  - Back-to-back grants give back-to-back `rd_valid`.
- Worst-case read stall: 1 cycle per MAX_STARVE grants while writes are pending.
- Simultaneous push and write-grant pop with the FIFO full: push accepted, `fifo_count` unchanged, no overflow.
- Simultaneous push and read grant: push lands, `fifo_count` +1.
- `wr_en` and a read of the same address in the same cycle: the read returns pre-write data (the entry is not yet in the FIFO).
- `rd_ready` is a function of `rd_req`, FIFO state and `starve_cnt` only. There is no combinational path from `ram_rdata` to it.

## Configuration
- `SAMPLE_RAM_ARB_BYPASS_EN`
- Defined:
  - A read grant compares `rd_addr` against all valid FIFO entries.
  - On a hit, the youngest matching entry's data is returned as `rd_data` at N+1, instead of `ram_rdata`.
  - The RAM read is still issued; only the data source changes.
- Undefined: no compare logic; `rd_data` is always `ram_rdata`.

## Test plan
- Write only:
  - Stimulus: reset 2 cycles, then `wr_en` pulses at addr 0x000..0x0FF with data 0x80+i every other cycle, `rd_req=0`.
  - Response: each RAM write 1 cycle after its `wr_en`; `fifo_count` ≤1; `overflow=0`.
- Read priority and starvation:
  - Stimulus: load 3 writes, then hold `rd_req=1` continuously.
  - Response: 8 read grants, then 1 write grant (`rd_ready=0` that cycle); repeats until the FIFO is empty; `rd_valid` follows every grant by 1 cycle.
- Overflow:
  - Stimulus: `rd_req=1` held, with MAX_STARVE=8; 6 consecutive `wr_en` pulses.
  - Response: `fifo_count` saturates at 4, the 5th write is dropped, `overflow=1` sticky until reset.
- Full with same-cycle pop:
  - Stimulus: FIFO at 4, `wr_en` on the cycle `starve_cnt` hits 8.
  - Response: push accepted, count stays 4, `overflow=0`.
- Bypass:
  - Stimulus: write 0x1A5←0x3C queued behind a read stream, then read 0x1A5 while it is still pending.
  - Response with `SAMPLE_RAM_ARB_BYPASS_EN` defined: `rd_data=0x3C`.
  - Response without it: the old RAM value.
- Reset mid-read:
  - Stimulus: assert `reset` the cycle after a read grant, with 2 FIFO entries pending.
  - Response: `rd_valid=0` next cycle; `fifo_count=0`; no RAM write issued afterward.
